// File: rtl/switch_input_reader.sv
// switch_input_reader: synchronise and debounce 16 switches and a pushbutton, publish press events over valid/ready
module switch_input_reader #(
    parameter int C_TICK_COUNT   = 10_000 - 1,
    parameter int C_STABLE_TICKS = 20,
    parameter int C_WIDTH        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] sw_in,
    input  logic               btn_in,
    output logic [C_WIDTH-1:0] sw_out,
    output logic               sw_changed,
    output logic               press_valid,
    output logic [C_WIDTH-1:0] press_data,
    input  logic               press_ready,
    output logic               press_overrun
);
    localparam int            CW    = C_STABLE_TICKS > 1 ? $clog2(C_STABLE_TICKS) : 1;
    localparam logic [CW-1:0] C_MAX = CW'(C_STABLE_TICKS - 1);
    localparam logic [23:0]   C_TICK = 24'(C_TICK_COUNT);

    logic [C_WIDTH-1:0] r_sw_s1, r_sw_s2, r_sw_last, r_sw_out, r_press_data;
    logic               r_btn_s1, r_btn_s2, r_btn_last, r_btn_db;
    logic [CW-1:0]      r_sw_cnt, r_btn_cnt;
    logic [23:0]        r_tick_cnt;
    logic               r_sw_changed, r_press_valid, r_press_overrun;

    logic               w_tick, w_sw_acc, w_btn_acc, w_press, w_take;
    logic [C_WIDTH-1:0] w_sw_next;

    assign w_tick    = r_tick_cnt == C_TICK;
    assign w_sw_acc  = w_tick && r_sw_s2 == r_sw_last && r_sw_cnt == C_MAX && r_sw_last != r_sw_out;
    assign w_btn_acc = w_tick && r_btn_s2 == r_btn_last && r_btn_cnt == C_MAX && r_btn_last != r_btn_db;
    assign w_press   = w_btn_acc && r_btn_last;
    assign w_take    = r_press_valid && press_ready;
    assign w_sw_next = w_sw_acc ? r_sw_last : r_sw_out;

    assign sw_out        = r_sw_out;
    assign sw_changed    = r_sw_changed;
    assign press_valid   = r_press_valid;
    assign press_data    = r_press_data;
    assign press_overrun = r_press_overrun;

    // two-flop synchronisers and the free-running sample tick divider
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_sw_s1    <= sw_in;
            r_sw_s2    <= r_sw_s1;
            r_btn_s1   <= btn_in;
            r_btn_s2   <= r_btn_s1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 24'd1;
        end
    end

    // whole-vector switch debounce; a new word is published with a one-cycle change pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_last    <= '0;
            r_sw_cnt     <= '0;
            r_sw_out     <= '0;
            r_sw_changed <= 1'b0;
        end else begin
            if (w_tick) begin
                if (r_sw_s2 == r_sw_last) begin
                    r_sw_cnt <= (r_sw_cnt == C_MAX) ? r_sw_cnt : r_sw_cnt + 1'b1;
                end else begin
                    r_sw_last <= r_sw_s2;
                    r_sw_cnt  <= '0;
                end
            end
            if (w_sw_acc) r_sw_out <= r_sw_last;
            r_sw_changed <= w_sw_acc;
        end
    end

    // button debounce with the same qualification rules as the switches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_last <= 1'b0;
            r_btn_cnt  <= '0;
            r_btn_db   <= 1'b0;
        end else begin
            if (w_tick) begin
                if (r_btn_s2 == r_btn_last) begin
                    r_btn_cnt <= (r_btn_cnt == C_MAX) ? r_btn_cnt : r_btn_cnt + 1'b1;
                end else begin
                    r_btn_last <= r_btn_s2;
                    r_btn_cnt  <= '0;
                end
            end
            if (w_btn_acc) r_btn_db <= r_btn_last;
        end
    end

    // press event slot: snapshot the post-edge switch word, drop and flag presses that find the slot busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_press_valid   <= 1'b0;
            r_press_data    <= '0;
            r_press_overrun <= 1'b0;
        end else if (w_press) begin
            if (!r_press_valid || w_take) begin
                r_press_valid <= 1'b1;
                r_press_data  <= w_sw_next;
            end else begin
                r_press_overrun <= 1'b1;
            end
        end else if (w_take) begin
            r_press_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_switch_input_reader.sv
// tb_switch_input_reader: directed scenarios for debounce timing, press handshake and reset behaviour
module tb_switch_input_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw_in;
    logic        btn_in;
    logic [15:0] sw_out;
    logic        sw_changed;
    logic        press_valid;
    logic [15:0] press_data;
    logic        press_ready;
    logic        press_overrun;
    int          checks = 0;
    int          errors = 0;

    switch_input_reader #(.C_TICK_COUNT(3), .C_STABLE_TICKS(3), .C_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .btn_in(btn_in),
        .sw_out(sw_out), .sw_changed(sw_changed), .press_valid(press_valid),
        .press_data(press_data), .press_ready(press_ready), .press_overrun(press_overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sw_in = 16'h00A5; btn_in = 1'b0; press_ready = 1'b0; reset = 1'b1;
        step(); step();
        checks++; if (sw_out !== 16'h0) begin errors++; $display("FAIL reset_sw_out got %h exp 0000", sw_out); end
        checks++; if (sw_changed !== 1'b0) begin errors++; $display("FAIL reset_sw_changed got %b exp 0", sw_changed); end
        checks++; if (press_valid !== 1'b0) begin errors++; $display("FAIL reset_press_valid got %b exp 0", press_valid); end
        checks++; if (press_data !== 16'h0) begin errors++; $display("FAIL reset_press_data got %h exp 0000", press_data); end
        checks++; if (press_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", press_overrun); end
    endtask

    task automatic test_first_accept();
        int early = 0;
        int late = 0;
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (sw_changed || sw_out !== 16'h0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL accept_early got %0d exp 0", early); end
        step();
        checks++; if (sw_out !== 16'h00A5) begin errors++; $display("FAIL accept_sw_out got %h exp 00a5", sw_out); end
        checks++; if (sw_changed !== 1'b1) begin errors++; $display("FAIL accept_pulse got %b exp 1", sw_changed); end
        for (int i = 0; i < 30; i++) begin
            step();
            if (sw_changed) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL accept_extra_pulses got %0d exp 0", late); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 12; i++) begin
            sw_in = (i % 2 == 0) ? 16'h00A4 : 16'h00A5;
            for (int j = 0; j < 5; j++) begin
                step();
                if (sw_changed) pulses++;
            end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_pulses got %0d exp 0", pulses); end
        checks++; if (sw_out !== 16'h00A5) begin errors++; $display("FAIL bounce_sw_out got %h exp 00a5", sw_out); end
        sw_in = 16'h00A4;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sw_changed) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
        checks++; if (sw_out !== 16'h00A4) begin errors++; $display("FAIL hold_sw_out got %h exp 00a4", sw_out); end
    endtask

    task automatic test_press();
        int rises = 0;
        logic prev = 1'b0;
        sw_in = 16'h1234;
        for (int i = 0; i < 40 && sw_out !== 16'h1234; i++) step();
        checks++; if (sw_out !== 16'h1234) begin errors++; $display("FAIL press_setup_sw got %h exp 1234", sw_out); end
        for (int b = 0; b < 3; b++) begin
            btn_in = 1'b1;
            for (int j = 0; j < 3; j++) begin step(); if (press_valid && !prev) rises++; prev = press_valid; end
            btn_in = 1'b0;
            for (int j = 0; j < 3; j++) begin step(); if (press_valid && !prev) rises++; prev = press_valid; end
        end
        btn_in = 1'b1;
        for (int j = 0; j < 40; j++) begin step(); if (press_valid && !prev) rises++; prev = press_valid; end
        checks++; if (rises != 1) begin errors++; $display("FAIL press_rises got %0d exp 1", rises); end
        checks++; if (press_valid !== 1'b1) begin errors++; $display("FAIL press_held got %b exp 1", press_valid); end
        checks++; if (press_data !== 16'h1234) begin errors++; $display("FAIL press_data got %h exp 1234", press_data); end
        press_ready = 1'b1;
        step();
        press_ready = 1'b0;
        checks++; if (press_valid !== 1'b0) begin errors++; $display("FAIL press_accept got %b exp 0", press_valid); end
        checks++; if (press_overrun !== 1'b0) begin errors++; $display("FAIL press_overrun got %b exp 0", press_overrun); end
    endtask

    task automatic test_overrun();
        btn_in = 1'b0;
        repeat (30) step();
        checks++; if (press_valid !== 1'b0) begin errors++; $display("FAIL release_event got %b exp 0", press_valid); end
        btn_in = 1'b1;
        for (int i = 0; i < 40 && !press_valid; i++) step();
        checks++; if (press_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_press got %b exp 1", press_valid); end
        btn_in = 1'b0;
        repeat (30) step();
        sw_in = 16'h5678;
        for (int i = 0; i < 40 && sw_out !== 16'h5678; i++) step();
        checks++; if (sw_out !== 16'h5678) begin errors++; $display("FAIL ovr_sw got %h exp 5678", sw_out); end
        btn_in = 1'b1;
        repeat (30) step();
        checks++; if (press_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", press_overrun); end
        checks++; if (press_data !== 16'h1234) begin errors++; $display("FAIL ovr_data got %h exp 1234", press_data); end
        checks++; if (press_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", press_valid); end
        btn_in = 1'b0; sw_in = 16'h0; reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({sw_out, sw_changed, press_valid, press_data, press_overrun} !== 35'h0) begin
            errors++; $display("FAIL ovr_reset got %h/%b/%b/%h/%b exp all 0", sw_out, sw_changed, press_valid, press_data, press_overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic seen = 1'b0;
        sw_in = 16'h1111;
        for (int i = 0; i < 40 && sw_out !== 16'h1111; i++) step();
        btn_in = 1'b1;
        for (int i = 0; i < 40 && !press_valid; i++) step();
        btn_in = 1'b0;
        repeat (30) step();
        checks++; if (press_valid !== 1'b1 || press_data !== 16'h1111) begin
            errors++; $display("FAIL b2b_pending got %b/%h exp 1/1111", press_valid, press_data);
        end
        sw_in = 16'h2222;
        for (int i = 0; i < 40 && !seen; i++) begin step(); seen = sw_changed; end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_sw_change got 0 exp 1"); end
        step();
        btn_in = 1'b1;
        repeat (14) step();
        checks++; if (press_valid !== 1'b1 || press_data !== 16'h1111) begin
            errors++; $display("FAIL b2b_before got %b/%h exp 1/1111", press_valid, press_data);
        end
        press_ready = 1'b1;
        step();
        press_ready = 1'b0;
        checks++; if (press_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", press_valid); end
        checks++; if (press_data !== 16'h2222) begin errors++; $display("FAIL b2b_data got %h exp 2222", press_data); end
        checks++; if (press_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", press_overrun); end
        btn_in = 1'b0;
        step();
    endtask

    task automatic test_reset_midqual();
        int early = 0;
        sw_in = 16'hFFFF;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (sw_out !== 16'h0 || press_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got %h/%b exp 0000/0", sw_out, press_valid);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            if (sw_changed || sw_out !== 16'h0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL mid_early got %0d exp 0", early); end
        step();
        checks++; if (sw_out !== 16'hFFFF || sw_changed !== 1'b1) begin
            errors++; $display("FAIL mid_accept got %h/%b exp ffff/1", sw_out, sw_changed);
        end
        step();
        checks++; if (sw_changed !== 1'b0) begin errors++; $display("FAIL mid_pulse_width got %b exp 0", sw_changed); end
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_bounce();
        test_press();
        test_overrun();
        test_back_to_back();
        test_reset_midqual();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
